// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_stage and ifid_reg.
package fetch_pkg;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    RUN        = 2'd1,
    HALT       = 2'd2
  } fetch_state_t;

  localparam logic [23:0] NOP_INSTR          = 24'h000000;
  localparam logic [23:0] DEFAULT_HALT_INSTR = 24'hFFFFFF;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: async reset, bubble-load (flush) beats hold (stall) beats load.
// A bubble clears every field so a squashed slot never carries a stale PC downstream.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IW    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic [IW-1:0]    d_instr,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [WIDTH-1:0] d_pc_plus,
  output logic [IW-1:0]    q_instr,
  output logic [WIDTH-1:0] q_pc,
  output logic [WIDTH-1:0] q_pc_plus,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_instr   <= IW'(NOP_INSTR);
      q_pc      <= '0;
      q_pc_plus <= '0;
      q_valid   <= 1'b0;
    end else if (bubble) begin
      q_instr   <= IW'(NOP_INSTR);
      q_pc      <= '0;
      q_pc_plus <= '0;
      q_valid   <= 1'b0;
    end else if (!hold) begin
      q_instr   <= d_instr;
      q_pc      <= d_pc;
      q_pc_plus <= d_pc_plus;
      q_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from the instruction port, fills IF/ID.
// Optional fetch-address bound check is compiled in with `define FETCH_BOUND_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                          WIDTH            = 32,
  parameter int                          INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0]            RESET_PC         = '0,
  parameter int unsigned                 PC_INC           = 1,
  parameter int unsigned                 IMEM_WORDS       = 1024,
  parameter logic [INSTRUCTIONWIDTH-1:0] HALT_INSTR       = INSTRUCTIONWIDTH'(DEFAULT_HALT_INSTR)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            branch_target,
  input  logic [INSTRUCTIONWIDTH-1:0] instr_mem_rd,
  output logic [WIDTH-1:0]            instr_mem_addr,
  output logic [INSTRUCTIONWIDTH-1:0] instr_out,
  output logic [WIDTH-1:0]            pc_out,
  output logic [WIDTH-1:0]            pc_plus_out,
  output logic                        valid_out,
  output logic                        halted,
  output logic                        fetch_fault,
  output fetch_state_t                state_dbg
);

  // IF/ID contract: valid_out=1 means instr_out/pc_out/pc_plus_out describe a real fetched
  // instruction; there is no ready, stall is the only back-pressure and it freezes everything.

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc, pc_next, pc_plus;
  logic             ifid_hold, ifid_bubble;

  assign pc_plus        = pc + WIDTH'(PC_INC);
  assign instr_mem_addr = pc;
  assign halted         = (state == HALT);
  assign state_dbg      = state;

`ifdef FETCH_BOUND_CHECK_EN
  logic pc_oob, fault_set, fault_q;
  assign pc_oob = (pc >= WIDTH'(IMEM_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
  assign fetch_fault = fault_q;
`else
  logic unused_bound;
  assign unused_bound = (pc >= WIDTH'(IMEM_WORDS));
  assign fetch_fault  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_START;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
    fault_set   = 1'b0;
`endif
    unique case (state)
      WAIT_START: begin
        ifid_bubble = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_next     = branch_target;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end
`ifdef FETCH_BOUND_CHECK_EN
        else if (pc_oob) begin
          ifid_bubble = 1'b1;
          fault_set   = 1'b1;
          state_next  = HALT;
        end
`endif
        else begin
          // The halt word itself is latched as a valid instruction; pc stays on it.
          if (instr_mem_rd == HALT_INSTR) state_next = HALT;
          else pc_next = pc_plus;
        end
      end
      HALT: begin
        // A branch here means the halt was fetched down a mispredicted path.
        if (branch_taken) begin
          pc_next     = branch_target;
          ifid_bubble = 1'b1;
          state_next  = RUN;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
      end
      default: begin
        state_next  = WAIT_START;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  ifid_reg #(
    .WIDTH (WIDTH),
    .IW    (INSTRUCTIONWIDTH)
  ) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .hold      (ifid_hold),
    .bubble    (ifid_bubble),
    .d_instr   (instr_mem_rd),
    .d_pc      (pc),
    .d_pc_plus (pc_plus),
    .q_instr   (instr_out),
    .q_pc      (pc_out),
    .q_pc_plus (pc_plus_out),
    .q_valid   (valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
// Expected IF/ID contents are queued per step and compared after the clock edge.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int W   = 32;
  localparam int IW  = 24;
  localparam int EW  = 1 + IW + W + W + 1 + 1;
  localparam logic [IW-1:0] HALT_W = 24'hFFFFFF;

  logic          clk, rst, start, stall, branch_taken;
  logic [W-1:0]  branch_target;
  logic [IW-1:0] instr_mem_rd;
  logic [W-1:0]  instr_mem_addr, pc_out, pc_plus_out;
  logic [IW-1:0] instr_out;
  logic          valid_out, halted, fetch_fault;
  fetch_state_t  state_dbg;

  logic          halt_en;
  logic [W-1:0]  halt_addr;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .WIDTH      (W),
    .INSTRUCTIONWIDTH (IW),
    .RESET_PC   (32'h0),
    .PC_INC     (1),
    .IMEM_WORDS (128),
    .HALT_INSTR (HALT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_mem_rd   (instr_mem_rd),
    .instr_mem_addr (instr_mem_addr),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus_out    (pc_plus_out),
    .valid_out      (valid_out),
    .halted         (halted),
    .fetch_fault    (fetch_fault),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction memory: address-tagged words, one fixed word at 3, optional halt word
  always_comb begin
    if (halt_en && instr_mem_addr == halt_addr) instr_mem_rd = HALT_W;
    else if (instr_mem_addr == 32'd3)            instr_mem_rd = 24'h123456;
    else                                         instr_mem_rd = {8'h5A, instr_mem_addr[15:0]};
  end

  function automatic logic [IW-1:0] mw(input logic [W-1:0] a);
    return {8'h5A, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic v, input logic [IW-1:0] i, input logic [W-1:0] pc,
                          input logic [W-1:0] addr, input logic h, input logic f);
    exp_q.push_back({v, i, pc, addr, h, f});
  endtask

  task automatic check_out();
    logic [EW-1:0] e;
    logic          e_v, e_h, e_f;
    logic [IW-1:0] e_i;
    logic [W-1:0]  e_pc, e_addr;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    {e_v, e_i, e_pc, e_addr, e_h, e_f} = e;
    chk("valid_out", W'(valid_out), W'(e_v));
    chk("instr_out", W'(instr_out), W'(e_i));
    chk("instr_mem_addr", instr_mem_addr, e_addr);
    chk("halted", W'(halted), W'(e_h));
    chk("fetch_fault", W'(fetch_fault), W'(e_f));
    if (e_v) begin
      chk("pc_out", pc_out, e_pc);
      chk("pc_plus_out", pc_plus_out, e_pc + 32'd1);
    end
  endtask

  // driver: inputs change on the falling edge, outputs checked on the next falling edge
  task automatic step(input logic s, input logic st, input logic br, input logic [W-1:0] tgt,
                      input logic v, input logic [IW-1:0] i, input logic [W-1:0] pc,
                      input logic [W-1:0] addr, input logic h, input logic f);
    start = s; stall = st; branch_taken = br; branch_target = tgt;
    push_exp(v, i, pc, addr, h, f);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    halt_en = 1'b0; halt_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(1'b0, 24'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_out();
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_pc_plus", pc_plus_out, 32'h0);
    chk("reset_state", W'(state_dbg), W'(WAIT_START));

    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 24'h0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0, 32'h0, 0, 0);
    chk("state_run", W'(state_dbg), W'(RUN));
    step(0, 0, 0, 0, 1, mw(0), 32'h0, 32'h1, 0, 0);
    step(0, 0, 0, 0, 1, mw(1), 32'h1, 32'h2, 0, 0);
    step(1, 0, 0, 0, 1, mw(2), 32'h2, 32'h3, 0, 0);
    step(0, 0, 0, 0, 1, 24'h123456, 32'h3, 32'h4, 0, 0);
    step(0, 1, 0, 0, 1, 24'h123456, 32'h3, 32'h4, 0, 0);
    step(0, 1, 0, 0, 1, 24'h123456, 32'h3, 32'h4, 0, 0);
    step(0, 0, 0, 0, 1, mw(4), 32'h4, 32'h5, 0, 0);

    step(0, 1, 1, 32'h40, 0, 24'h0, 0, 32'h40, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'h40), 32'h40, 32'h41, 0, 0);

    halt_en = 1'b1; halt_addr = 32'h5;
    step(0, 0, 1, 32'h5, 0, 24'h0, 0, 32'h5, 0, 0);
    step(0, 0, 0, 0, 1, HALT_W, 32'h5, 32'h5, 1, 0);
    chk("state_halt", W'(state_dbg), W'(HALT));
    step(0, 1, 0, 0, 1, HALT_W, 32'h5, 32'h5, 1, 0);
    step(0, 0, 0, 0, 0, 24'h0, 0, 32'h5, 1, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0, 32'h5, 1, 0);
    step(0, 0, 1, 32'h10, 0, 24'h0, 0, 32'h10, 0, 0);
    halt_en = 1'b0;
    step(0, 0, 0, 0, 1, mw(32'h10), 32'h10, 32'h11, 0, 0);

    step(0, 0, 1, 32'h20, 0, 24'h0, 0, 32'h20, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'h20), 32'h20, 32'h21, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'h21), 32'h21, 32'h22, 0, 0);

    // asynchronous reset in the middle of a cycle, with stall and branch both active
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h99;
    #2 rst = 1'b1;
    #1;
    chk("midrst_addr", instr_mem_addr, 32'h0);
    chk("midrst_valid", W'(valid_out), 32'h0);
    chk("midrst_instr", W'(instr_out), 32'h0);
    chk("midrst_pc_out", pc_out, 32'h0);
    chk("midrst_pc_plus", pc_plus_out, 32'h0);
    chk("midrst_state", W'(state_dbg), W'(WAIT_START));
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 24'h0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 24'h0, 0, 32'h0, 0, 0);

`ifndef FETCH_BOUND_CHECK_EN
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 24'h0, 0, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'hFFFF_FFFF), 32'hFFFF_FFFF, 32'h0, 0, 0);
    chk("wrap_pc_plus", pc_plus_out, 32'h0);
`endif

    step(0, 0, 1, 32'h7E, 0, 24'h0, 0, 32'h7E, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'h7E), 32'h7E, 32'h7F, 0, 0);
    step(0, 0, 0, 0, 1, mw(32'h7F), 32'h7F, 32'h80, 0, 0);
`ifdef FETCH_BOUND_CHECK_EN
    step(0, 0, 0, 0, 0, 24'h0, 0, 32'h80, 1, 1);
    step(0, 0, 1, 32'h0, 0, 24'h0, 0, 32'h0, 0, 1);
    step(0, 0, 0, 0, 1, mw(0), 32'h0, 32'h1, 0, 1);
`else
    step(0, 0, 0, 0, 1, mw(32'h80), 32'h80, 32'h81, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
